ch_param_loader: RTL and testbench

CH_PARAM_LOADER -- requirements
Module: ch_param_loader

---
 rtl/ch_param_pkg.sv | 35 +++
 rtl/ch_param_bank.sv | 63 ++++++
 rtl/ch_param_loader.sv | 140 ++++++++++++++
 tb/tb_ch_param_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ch_param_pkg.sv
// rtl/ch_param_pkg.sv - shared states, pids, ack codes and defaults for the channel parameter loader
package ch_param_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DHI,
      ST_DLO,
      ST_CSUM,
      ST_EXEC
   } state_t;

   typedef enum logic [1:0] {
      ACK_OK        = 2'd0,
      ACK_BAD_CSUM  = 2'd1,
      ACK_BAD_ADDR  = 2'd2,
      ACK_BAD_VALUE = 2'd3
   } ack_t;

   localparam logic [3:0] PID_FEQ   = 4'h0;
   localparam logic [3:0] PID_SCL   = 4'h1;
   localparam logic [3:0] PID_DUTY  = 4'h2;
   localparam logic [3:0] PID_DELAY = 4'h3;
   localparam logic [3:0] PID_APPLY = 4'hF;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam logic [15:0] DEF_FEQ   = 16'd1000;
   localparam logic [15:0] DEF_SCL   = 16'd50000;
   localparam logic [15:0] DEF_DUTY  = 16'd0;
   localparam logic [15:0] DEF_DELAY = 16'd0;

   localparam int MIN_DIV_DEF = 763;

endpackage

// File: rtl/ch_param_bank.sv
// rtl/ch_param_bank.sv - per-channel shadow and active parameter registers
// Writes land in shadow only; apply copies every channel's shadow to active at once.
module ch_param_bank
   import ch_param_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [3:0]           wr_ch,
   input  logic [1:0]           wr_sel,
   input  logic [15:0]          wr_data,
   input  logic                 apply,
   output logic [NUM_CH*16-1:0] ch_feq,
   output logic [NUM_CH*16-1:0] ch_scl,
   output logic [NUM_CH*16-1:0] ch_duty,
   output logic [NUM_CH*16-1:0] ch_delay,
   output logic                 apply_pulse
);

   logic [15:0] sh_feq   [NUM_CH];
   logic [15:0] sh_scl   [NUM_CH];
   logic [15:0] sh_duty  [NUM_CH];
   logic [15:0] sh_delay [NUM_CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sh_feq[i]              <= DEF_FEQ;
            sh_scl[i]              <= DEF_SCL;
            sh_duty[i]             <= DEF_DUTY;
            sh_delay[i]            <= DEF_DELAY;
            ch_feq[i*16 +: 16]     <= DEF_FEQ;
            ch_scl[i*16 +: 16]     <= DEF_SCL;
            ch_duty[i*16 +: 16]    <= DEF_DUTY;
            ch_delay[i*16 +: 16]   <= DEF_DELAY;
         end
         apply_pulse <= 1'b0;
      end else begin
         // pulse is registered alongside the active copy so both appear on the same cycle
         apply_pulse <= apply;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && wr_ch == 4'(i)) begin
               case (wr_sel)
                  2'd0: sh_feq[i]   <= wr_data;
                  2'd1: sh_scl[i]   <= wr_data;
                  2'd2: sh_duty[i]  <= wr_data;
                  2'd3: sh_delay[i] <= wr_data;
                  default: ;
               endcase
            end
            if (apply) begin
               ch_feq[i*16 +: 16]   <= sh_feq[i];
               ch_scl[i*16 +: 16]   <= sh_scl[i];
               ch_duty[i*16 +: 16]  <= sh_duty[i];
               ch_delay[i*16 +: 16] <= sh_delay[i];
            end
         end
      end
   end

endmodule

// File: rtl/ch_param_loader.sv
// rtl/ch_param_loader.sv - byte-stream frame parser, FSM and inter-byte timeout
// Define CH_PARAM_CHECKSUM_EN for 5-byte frames carrying an XOR checksum; otherwise frames are 4 bytes.
module ch_param_loader
   import ch_param_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int MIN_DIV     = MIN_DIV_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NUM_CH*16-1:0] ch_feq,
   output logic [NUM_CH*16-1:0] ch_scl,
   output logic [NUM_CH*16-1:0] ch_duty,
   output logic [NUM_CH*16-1:0] ch_delay,
   output logic                 apply_pulse,
   output logic                 ack_valid,
   output logic [1:0]           ack_code
);

   localparam int              CW       = $clog2(TIMEOUT_CYC + 2);
   localparam logic [CW-1:0]   TO_MAX   = CW'(TIMEOUT_CYC);
   localparam logic [15:0]     MIN_VAL  = 16'(MIN_DIV);
   localparam logic [4:0]      NUM_CH_V = 5'(NUM_CH);

   state_t        state, state_nxt;
   logic [7:0]    hdr;
   logic [15:0]   data;
`ifdef CH_PARAM_CHECKSUM_EN
   logic [7:0]    csum;
`endif
   logic [CW-1:0] to_cnt;
   logic [3:0]    ch, pid;
   logic          accept, in_frame, timeout, is_exec, is_apply;
   logic          wr_en, apply;
   ack_t          code;

   assign in_ready = (state != ST_EXEC);
   assign accept   = in_valid && in_ready;
   assign ch       = hdr[7:4];
   assign pid      = hdr[3:0];
   assign is_exec  = (state == ST_EXEC);
   assign is_apply = (pid == PID_APPLY);
   assign in_frame = (state == ST_HDR) || (state == ST_DHI) ||
                     (state == ST_DLO) || (state == ST_CSUM);
   assign timeout  = in_frame && !accept && (to_cnt == TO_MAX);

   // later assignments take priority: checksum over address over value
   always_comb begin
      code = ACK_OK;
      if ((pid == PID_FEQ || pid == PID_SCL) && data < MIN_VAL)
         code = ACK_BAD_VALUE;
      if (!is_apply && (pid[3:2] != 2'b00 || {1'b0, ch} >= NUM_CH_V))
         code = ACK_BAD_ADDR;
`ifdef CH_PARAM_CHECKSUM_EN
      if (csum != (hdr ^ data[15:8] ^ data[7:0]))
         code = ACK_BAD_CSUM;
`endif
   end

   assign ack_valid = is_exec;
   assign ack_code  = is_exec ? code : ACK_OK;
   assign wr_en     = is_exec && (code == ACK_OK) && !is_apply;
   assign apply     = is_exec && (code == ACK_OK) && is_apply;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept && in_data == SYNC_BYTE) state_nxt = ST_HDR;
         ST_HDR:  if (accept) state_nxt = ST_DHI;
         ST_DHI:  if (accept) state_nxt = ST_DLO;
`ifdef CH_PARAM_CHECKSUM_EN
         ST_DLO:  if (accept) state_nxt = ST_CSUM;
`else
         ST_DLO:  if (accept) state_nxt = ST_EXEC;
`endif
         ST_CSUM: if (accept) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (timeout)
         state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hdr  <= 8'h00;
         data <= 16'h0000;
`ifdef CH_PARAM_CHECKSUM_EN
         csum <= 8'h00;
`endif
      end else if (accept) begin
         case (state)
            ST_HDR:  hdr        <= in_data;
            ST_DHI:  data[15:8] <= in_data;
            ST_DLO:  data[7:0]  <= in_data;
`ifdef CH_PARAM_CHECKSUM_EN
            ST_CSUM: csum       <= in_data;
`endif
            default: ;
         endcase
      end
   end

   // saturates at TO_MAX; one further idle cycle there trips the timeout
   always_ff @(posedge clk) begin
      if (rst || !in_frame || accept)
         to_cnt <= '0;
      else if (to_cnt != TO_MAX)
         to_cnt <= to_cnt + 1'b1;
   end

   ch_param_bank #(
      .NUM_CH (NUM_CH)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_ch       (ch),
      .wr_sel      (pid[1:0]),
      .wr_data     (data),
      .apply       (apply),
      .ch_feq      (ch_feq),
      .ch_scl      (ch_scl),
      .ch_duty     (ch_duty),
      .ch_delay    (ch_delay),
      .apply_pulse (apply_pulse)
   );

endmodule

// File: tb/tb_ch_param_loader.sv
// tb/tb_ch_param_loader.sv - directed scoreboard bench for ch_param_loader
module tb_ch_param_loader;

   localparam int NUM_CH = 4;
   localparam int TO     = 20;

   localparam logic [63:0] FEQ_DEF = {4{16'h03E8}};
   localparam logic [63:0] SCL_DEF = {4{16'hC350}};

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [7:0]           in_data = 8'h00;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [NUM_CH*16-1:0] ch_feq, ch_scl, ch_duty, ch_delay;
   logic                 apply_pulse, ack_valid;
   logic [1:0]           ack_code;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;
   int exp_acks = 0;
   logic [1:0] exp_q[$];

   ch_param_loader #(
      .NUM_CH      (NUM_CH),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ch_feq      (ch_feq),
      .ch_scl      (ch_scl),
      .ch_duty     (ch_duty),
      .ch_delay    (ch_delay),
      .apply_pulse (apply_pulse),
      .ack_valid   (ack_valid),
      .ack_code    (ack_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ack_valid === 1'b1) ack_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_acks(input string tag);
      #1;
      chk(tag, 64'(ack_cnt), 64'(exp_acks));
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n == 10) chk("in_ready_wait", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // pops the scoreboard on the cycle following the final byte
   task automatic check_ack(input string tag);
      logic [1:0] e;
      chk({tag, "_valid"}, 64'(ack_valid), 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_code"}, 64'(ack_code), 64'(e));
      end
   endtask

   task automatic send_frame(input string tag, input logic [7:0] hdr, input logic [15:0] data,
                             input logic [7:0] flip, input logic [1:0] exp);
      exp_q.push_back(exp);
      exp_acks++;
      send_byte(8'hA5);
      send_byte(hdr);
      send_byte(data[15:8]);
      send_byte(data[7:0]);
`ifdef CH_PARAM_CHECKSUM_EN
      send_byte(hdr ^ data[15:8] ^ data[7:0] ^ flip);
`else
      if (flip != 8'h00) chk({tag, "_flip_unused"}, 64'(flip), 64'd0);
`endif
      check_ack(tag);
   endtask

   task automatic chk_defaults(input string tag);
      chk({tag, "_feq"},   ch_feq,   FEQ_DEF);
      chk({tag, "_scl"},   ch_scl,   SCL_DEF);
      chk({tag, "_duty"},  ch_duty,  64'd0);
      chk({tag, "_delay"}, ch_delay, 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_ack_valid", 64'(ack_valid), 64'd0);
      chk("rst_ack_code", 64'(ack_code), 64'd0);
      chk("rst_apply_pulse", 64'(apply_pulse), 64'd0);
      chk_defaults("rst");

      // write ch1 delay, shadow only
      send_frame("wr_delay", 8'h13, 16'h0005, 8'h00, 2'd0);
      chk("wr_delay_exec_pulse", 64'(apply_pulse), 64'd0);
      @(negedge clk);
      chk("wr_delay_not_active", ch_delay, 64'd0);
      chk("wr_delay_no_pulse", 64'(apply_pulse), 64'd0);

      send_frame("apply1", 8'h0F, 16'h0000, 8'h00, 2'd0);
      chk("apply1_exec_delay", ch_delay, 64'd0);
      chk("apply1_exec_pulse", 64'(apply_pulse), 64'd0);
      @(negedge clk);
      chk("apply1_pulse", 64'(apply_pulse), 64'd1);
      chk("apply1_delay", ch_delay, 64'h0000_0000_0005_0000);
      @(negedge clk);
      chk("apply1_pulse_off", 64'(apply_pulse), 64'd0);

      // MIN_DIV boundaries and full-range duty
      send_frame("feq_762", 8'h00, 16'h02FA, 8'h00, 2'd3);
      send_frame("feq_763", 8'h20, 16'h02FB, 8'h00, 2'd0);
      send_frame("scl_762", 8'h31, 16'h02FA, 8'h00, 2'd3);
      send_frame("duty_max", 8'h22, 16'hFFFF, 8'h00, 2'd0);
      send_frame("apply2", 8'h0F, 16'h0000, 8'h00, 2'd0);
      @(negedge clk);
      chk("apply2_feq_ch0", 64'(ch_feq[15:0]), 64'd1000);
      chk("apply2_feq", ch_feq, 64'h03E8_02FB_03E8_03E8);
      chk("apply2_scl", ch_scl, SCL_DEF);
      chk("apply2_duty", ch_duty, 64'h0000_FFFF_0000_0000);

      // bad channel / pid; apply ignores channel
      send_frame("hdr_42", 8'h42, 16'h1234, 8'h00, 2'd2);
      send_frame("hdr_07", 8'h07, 16'h1234, 8'h00, 2'd2);
      send_frame("hdr_14", 8'h14, 16'h1234, 8'h00, 2'd2);
      send_frame("apply_ch15", 8'hFF, 16'h0000, 8'h00, 2'd0);
      @(negedge clk);
      chk("rej_feq", ch_feq, 64'h03E8_02FB_03E8_03E8);
      chk("rej_scl", ch_scl, SCL_DEF);
      chk("rej_duty", ch_duty, 64'h0000_FFFF_0000_0000);
      chk("rej_delay", ch_delay, 64'h0000_0000_0005_0000);

      // sync value inside the frame is plain data
      send_frame("a5_data", 8'h32, 16'hA5A5, 8'h00, 2'd0);
      send_frame("apply3", 8'h0F, 16'h0000, 8'h00, 2'd0);
      @(negedge clk);
      chk("a5_duty", ch_duty, 64'hA5A5_FFFF_0000_0000);

`ifdef CH_PARAM_CHECKSUM_EN
      send_frame("csum_bad", 8'h23, 16'h1234, 8'h01, 2'd1);
      send_frame("csum_good", 8'h23, 16'h1234, 8'h00, 2'd0);
      send_frame("apply_cs", 8'h0F, 16'h0000, 8'h00, 2'd0);
      @(negedge clk);
      chk("csum_delay", ch_delay, 64'h0000_1234_0005_0000);
`endif

      // gap of exactly TO cycles keeps the frame alive
      exp_q.push_back(2'd0);
      exp_acks++;
      send_byte(8'hA5);
      send_byte(8'h10);
      repeat (TO) @(negedge clk);
      send_byte(8'h03);
      send_byte(8'hE8);
`ifdef CH_PARAM_CHECKSUM_EN
      send_byte(8'h10 ^ 8'h03 ^ 8'hE8);
`endif
      check_ack("gap_limit");

      // one more idle cycle drops the frame
      send_byte(8'hA5);
      send_byte(8'h10);
      repeat (TO + 1) @(negedge clk);
      chk_acks("timeout_no_ack");
      send_frame("after_timeout", 8'h01, 16'h0400, 8'h00, 2'd0);
      @(negedge clk);
      chk_acks("after_timeout_count");

      // reset mid-frame after the data-high byte
      send_byte(8'hA5);
      send_byte(8'h12);
      send_byte(8'h77);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_acks("rst_mid_no_ack");
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      chk_defaults("rst_mid");
      send_frame("post_rst_wr", 8'h02, 16'h1234, 8'h00, 2'd0);
      send_frame("post_rst_apply", 8'h0F, 16'h0000, 8'h00, 2'd0);
      @(negedge clk);
      chk("post_rst_duty", ch_duty, 64'h0000_0000_0000_1234);
      chk("post_rst_feq", ch_feq, FEQ_DEF);

      @(negedge clk);
      chk_acks("final_ack_count");
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
